axi_tx_response_gen: RTL and testbench
======================================

# axi_tx_response_gen

Transmit-side counterpart of the command decoder. It takes the tagged response stream from the chirp and FMC150 register blocks (read-back data and write acknowledgements) and frames it for the host link as: response code word, command ID word, then payload. It sits between the register-map response mux and the Ethernet TX packetiser. It enforces a maximum payload length and a minimum inter-frame gap.

## Interface
Parameters:
- MAX_PAYLOAD, 64, maximum payload words per frame (1..255)
- IFG_CYCLES, 24, idle cycles forced after each emitted frame (1..31)

Ports:
- axi_tclk  in  1  clock
- axi_tresetn  in  1  reset, asynchronous, active-low
- enable_tx_encode  in  1  allows a new frame to start; sampled only in IDLE
- rsp_axis_tdata  in  32  response payload word
- rsp_axis_tvalid  in  1  payload beat valid
- rsp_axis_tlast  in  1  last payload beat
- rsp_axis_tdest  in  4  source: 0 chirp write ack, 1 FMC150 write ack, 2 chirp read, 3 FMC150 read
- rsp_axis_tuser  in  32  command ID; held constant for the whole frame
- rsp_axis_tready  out  1  payload beat accepted
- tdata  out  32  framed output word
- tvalid  out  1  output valid
- tlast  out  1  last word of frame
- tready  in  1  downstream ready
- err_count  out  16  saturating count of dropped plus truncated frames
- busy  out  1  high in any state other than IDLE

## Operation
- Response codes, selected by tdest: 0 → 0x41414343 "AACC"; 1 → 0x41414646 "AAFF"; 2 → 0x44444343 "DDCC"; 3 → 0x44444646 "DDFF".
- States:
  - IDLE: when enable_tx_encode & rsp_axis_tvalid, capture tdest and tuser. The first beat is not consumed. Go to HEADER if tdest ≤ 3, otherwise go to DROP and increment err_count.
  - HEADER: emit the response code, then go to ID.
  - ID: emit the captured tuser, then go to PAYLOAD.
  - PAYLOAD: pass input beats to the output and count them in an 8-bit counter.
    - Input tlast: emit the beat with tlast=1, go to GAP.
    - Counter reaches MAX_PAYLOAD without input tlast: emit that beat with tlast=1, increment err_count, go to DROP.
  - DROP: rsp_axis_tready=1; discard beats. Exit to GAP on an accepted beat with rsp_axis_tlast, or to IDLE when entered from IDLE.
  - GAP: count down IFG_CYCLES, then go to IDLE.
- Output word generation:
  - Every output word is emitted through a single output register.
  - The register loads only when (!tvalid | tready).
  - A state advances only when its word is loaded.
- Payload with zero beats is impossible; every frame carries at least one payload beat.
- err_count saturates at 0xFFFF.
- enable_tx_encode deasserted mid-frame has no effect; the current frame completes.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, rsp_axis_tready=0, err_count=0, busy=0. The state machine enters IDLE.
- Latency:
  - From rsp_axis_tvalid sampled in IDLE to the header word on tvalid: 2 cycles.
  - Payload beat to output: 1 cycle.
- rsp_axis_tready is registered-equivalent combinational: PAYLOAD & (!tvalid | tready), or DROP.
- Handshake rules: tvalid never drops without tready, and tdata/tlast are stable while tvalid & !tready.
- Minimum gap from the last word's acceptance to the next header's tvalid: IFG_CYCLES + 2 cycles.
- Boundary cases:
  - Input tlast on beat number MAX_PAYLOAD is a normal end: no truncation, no err_count increment.
  - tready held low indefinitely stalls all states except GAP and DROP.
  - Asynchronous reset mid-frame clears all state immediately, and the partial frame is abandoned. The upstream source must also be reset.

## Structure
- Shared package axi_cmd_pkg holds:
  - command codes: WWCC, WWFF, RRCC, RRFF, WWDA
  - response codes: AACC, AAFF, DDCC, DDFF
  - tdest encodings
  - state enum
- The rx decoder is migrated to the same package.
- One sub-module: axis_out_reg. It is a single-entry register slice with load enable and the valid/ready hold logic, reused for the output stage.

## Test plan
- tdest=2, tuser=0x00000007, payload 0x11,0x22,0x33 with tlast on the third beat. Output must be 0x44444343, 0x00000007, 0x11, 0x22, 0x33 with tlast on the last word; err_count=0.
- Same frame with tready toggling 1,0,0,1 randomly. Output sequence is identical, with no duplicated or lost words, and tdata is stable while stalled.
- tdest=5, 4-beat payload. No output words; 4 beats consumed; err_count=1; return to IDLE.
- MAX_PAYLOAD=4 with a 6-beat frame (tdest=1):
  - Output is AAFF, ID, then 4 payload words, with tlast on the 4th payload word.
  - The 2 remaining beats are discarded; err_count=1.
- Two back-to-back frames:
  - Second header tvalid appears exactly IFG_CYCLES+2 cycles after the first frame's tlast handshake.
  - Asserting reset during the second frame's payload forces tvalid=0 asynchronously, and err_count is cleared.

Source files
------------

// File: rtl/axi_cmd_pkg.sv
// Shared definitions for the host-link command decoder and response generator:
// command/response code words, tdest source encodings and the TX framer state set.
package axi_cmd_pkg;

  // Command code words seen by the rx decoder (ASCII in the 32-bit word)
  localparam logic [31:0] CMD_WWCC = 32'h5757_4343;
  localparam logic [31:0] CMD_WWFF = 32'h5757_4646;
  localparam logic [31:0] CMD_RRCC = 32'h5252_4343;
  localparam logic [31:0] CMD_RRFF = 32'h5252_4646;
  localparam logic [31:0] CMD_WWDA = 32'h5757_4441;

  // Response code words placed at the head of every transmitted frame
  localparam logic [31:0] RSP_AACC = 32'h4141_4343;
  localparam logic [31:0] RSP_AAFF = 32'h4141_4646;
  localparam logic [31:0] RSP_DDCC = 32'h4444_4343;
  localparam logic [31:0] RSP_DDFF = 32'h4444_4646;

  // Response sources carried on tdest
  localparam logic [3:0] DEST_CHIRP_WACK = 4'd0;
  localparam logic [3:0] DEST_FMC_WACK   = 4'd1;
  localparam logic [3:0] DEST_CHIRP_RD   = 4'd2;
  localparam logic [3:0] DEST_FMC_RD     = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ID,
    ST_PAYLOAD,
    ST_DROP,
    ST_GAP
  } tx_state_t;

  // Map a response source to its header code word; unknown sources never reach HEADER
  function automatic logic [31:0] rsp_code(input logic [3:0] dest);
    logic [31:0] code;
    case (dest)
      DEST_CHIRP_WACK: code = RSP_AACC;
      DEST_FMC_WACK:   code = RSP_AAFF;
      DEST_CHIRP_RD:   code = RSP_DDCC;
      DEST_FMC_RD:     code = RSP_DDFF;
      default:         code = 32'h0000_0000;
    endcase
    return code;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream register slice. A word is loaded only when the slot
// is empty or is being taken this cycle; otherwise the held word stays stable.
module axis_out_reg
  import axi_cmd_pkg::*;
(
  input  logic        axi_tclk,
  input  logic        axi_tresetn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        tready,
  output logic [31:0] tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        can_load
);

  assign can_load = !tvalid | tready;

  // Hold the word until accepted; refill or empty the slot on acceptance
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      tdata  <= 32'h0000_0000;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load & can_load) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
    end else if (tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_tx_response_gen.sv
// Frames tagged register-block responses for the host link as
// response code, command ID, payload. Enforces a payload length cap
// (truncating over-long frames) and a fixed idle gap after each frame.
module axi_tx_response_gen
  import axi_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int IFG_CYCLES  = 24
) (
  input  logic        axi_tclk,
  input  logic        axi_tresetn,
  input  logic        enable_tx_encode,
  input  logic [31:0] rsp_axis_tdata,
  input  logic        rsp_axis_tvalid,
  input  logic        rsp_axis_tlast,
  input  logic [3:0]  rsp_axis_tdest,
  input  logic [31:0] rsp_axis_tuser,
  output logic        rsp_axis_tready,
  output logic [31:0] tdata,
  output logic        tvalid,
  output logic        tlast,
  input  logic        tready,
  output logic [15:0] err_count,
  output logic        busy
);

  localparam logic [7:0] LAST_BEAT_IDX = 8'(MAX_PAYLOAD - 1);
  localparam logic [4:0] GAP_INIT      = 5'(IFG_CYCLES);

  tx_state_t   state;
  logic [3:0]  cap_dest;
  logic [31:0] cap_user;
  logic [7:0]  beat_cnt;
  logic [4:0]  gap_cnt;
  logic        drop_from_idle;

  logic        out_load;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_can_load;

  // A payload beat is taken only in lockstep with loading it into the output slot
  assign rsp_axis_tready = ((state == ST_PAYLOAD) & out_can_load) | (state == ST_DROP);

  // Select the word offered to the output slot in each framing state
  always_comb begin
    out_load = 1'b0;
    out_data = 32'h0000_0000;
    out_last = 1'b0;
    case (state)
      ST_HEADER: begin
        out_load = out_can_load;
        out_data = rsp_code(cap_dest);
      end
      ST_ID: begin
        out_load = out_can_load;
        out_data = cap_user;
      end
      ST_PAYLOAD: begin
        out_load = out_can_load & rsp_axis_tvalid;
        out_data = rsp_axis_tdata;
        out_last = rsp_axis_tlast | (beat_cnt == LAST_BEAT_IDX);
      end
      default: begin
        out_load = 1'b0;
      end
    endcase
  end

  // Framing state machine with error counting and inter-frame gap timing
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state          <= ST_IDLE;
      cap_dest       <= 4'd0;
      cap_user       <= 32'h0000_0000;
      beat_cnt       <= 8'd0;
      gap_cnt        <= 5'd0;
      drop_from_idle <= 1'b0;
      err_count      <= 16'd0;
      busy           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_tx_encode & rsp_axis_tvalid) begin
            cap_dest <= rsp_axis_tdest;
            cap_user <= rsp_axis_tuser;
            busy     <= 1'b1;
            if (rsp_axis_tdest <= DEST_FMC_RD) begin
              state <= ST_HEADER;
            end else begin
              state          <= ST_DROP;
              drop_from_idle <= 1'b1;
              err_count      <= sat_inc16(err_count);
            end
          end
        end
        ST_HEADER: begin
          if (out_can_load) state <= ST_ID;
        end
        ST_ID: begin
          if (out_can_load) begin
            state    <= ST_PAYLOAD;
            beat_cnt <= 8'd0;
          end
        end
        ST_PAYLOAD: begin
          if (out_load) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (rsp_axis_tlast) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_INIT;
            end else if (beat_cnt == LAST_BEAT_IDX) begin
              state          <= ST_DROP;
              drop_from_idle <= 1'b0;
              err_count      <= sat_inc16(err_count);
            end
          end
        end
        ST_DROP: begin
          if (rsp_axis_tvalid & rsp_axis_tlast) begin
            if (drop_from_idle) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_INIT;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 5'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 5'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  axis_out_reg u_out_reg (
    .axi_tclk    (axi_tclk),
    .axi_tresetn (axi_tresetn),
    .load        (out_load),
    .load_data   (out_data),
    .load_last   (out_last),
    .tready      (tready),
    .tdata       (tdata),
    .tvalid      (tvalid),
    .tlast       (tlast),
    .can_load    (out_can_load)
  );

endmodule

// File: tb/tb_axi_tx_response_gen.sv
// Directed bench for axi_tx_response_gen with a 4-word payload cap and a
// 5-cycle inter-frame gap so truncation and gap timing are short to exercise.
module tb_axi_tx_response_gen;

  localparam int MAX_P = 4;
  localparam int IFG   = 5;

  logic        axi_tclk;
  logic        axi_tresetn;
  logic        enable_tx_encode;
  logic [31:0] rsp_axis_tdata;
  logic        rsp_axis_tvalid;
  logic        rsp_axis_tlast;
  logic [3:0]  rsp_axis_tdest;
  logic [31:0] rsp_axis_tuser;
  logic        rsp_axis_tready;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [15:0] err_count;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hs_cyc      = 0;
  int rise_cyc    = 0;
  int start_cyc   = 0;
  int rsp_beats   = 0;
  int stall_err   = 0;
  int tready_mode = 0;

  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];

  axi_tx_response_gen #(
    .MAX_PAYLOAD (MAX_P),
    .IFG_CYCLES  (IFG)
  ) dut (
    .axi_tclk         (axi_tclk),
    .axi_tresetn      (axi_tresetn),
    .enable_tx_encode (enable_tx_encode),
    .rsp_axis_tdata   (rsp_axis_tdata),
    .rsp_axis_tvalid  (rsp_axis_tvalid),
    .rsp_axis_tlast   (rsp_axis_tlast),
    .rsp_axis_tdest   (rsp_axis_tdest),
    .rsp_axis_tuser   (rsp_axis_tuser),
    .rsp_axis_tready  (rsp_axis_tready),
    .tdata            (tdata),
    .tvalid           (tvalid),
    .tlast            (tlast),
    .tready           (tready),
    .err_count        (err_count),
    .busy             (busy)
  );

  initial begin
    axi_tclk = 1'b0;
    forever #5 axi_tclk = ~axi_tclk;
  end

  // Downstream ready: always ready, or a repeating 1,0,0,1 stall pattern
  initial begin
    logic [3:0] pat;
    int pidx;
    pat  = 4'b1001;
    pidx = 0;
    tready = 1'b1;
    forever begin
      @(posedge axi_tclk);
      #1;
      if (tready_mode == 0) begin
        tready = 1'b1;
        pidx   = 0;
      end else begin
        tready = pat[pidx];
        pidx   = (pidx + 1) % 4;
      end
    end
  end

  // Observe both streams on the falling edge: accepted words, consumed beats,
  // edge timing and stability of a stalled output word
  initial begin
    logic        prev_tvalid;
    logic        hold_prev;
    logic [31:0] hold_data;
    logic        hold_last;
    prev_tvalid = 1'b0;
    hold_prev   = 1'b0;
    hold_data   = 32'h0;
    hold_last   = 1'b0;
    forever begin
      @(negedge axi_tclk);
      cyc = cyc + 1;
      if (axi_tresetn !== 1'b1) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && (tvalid !== 1'b1 || tdata !== hold_data || tlast !== hold_last))
          stall_err++;
        if (tvalid === 1'b1 && tready === 1'b1) begin
          out_q.push_back({tlast, tdata});
          if (tlast === 1'b1) hs_cyc = cyc;
        end
        if (tvalid === 1'b1 && prev_tvalid !== 1'b1) rise_cyc = cyc;
        if (rsp_axis_tvalid === 1'b1 && rsp_axis_tready === 1'b1) rsp_beats++;
        hold_prev = (tvalid === 1'b1) && (tready !== 1'b1);
        hold_data = tdata;
        hold_last = tlast;
      end
      prev_tvalid = tvalid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got still running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_frame(input logic [3:0] dest, input logic [31:0] user,
                            input int nbeats, input logic [31:0] base);
    int guard;
    @(posedge axi_tclk);
    #1;
    enable_tx_encode = 1'b1;
    rsp_axis_tdest   = dest;
    rsp_axis_tuser   = user;
    rsp_axis_tvalid  = 1'b1;
    start_cyc        = cyc;
    for (int i = 0; i < nbeats; i++) begin
      rsp_axis_tdata = base * 32'(i + 1);
      rsp_axis_tlast = (i == nbeats - 1);
      guard = 0;
      do begin
        @(negedge axi_tclk);
        guard++;
      end while (rsp_axis_tready !== 1'b1 && guard < 100);
      if (rsp_axis_tready !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL beat_accept beat %0d got rsp_tready=%b want 1", i, rsp_axis_tready);
      end
      @(posedge axi_tclk);
      #1;
      enable_tx_encode = 1'b0;
    end
    rsp_axis_tvalid = 1'b0;
    rsp_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge axi_tclk);
      guard++;
    end while ((busy !== 1'b0 || tvalid !== 1'b0) && guard < 200);
    vectors++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL return_idle got busy=%b tvalid=%b want 0 0", busy, tvalid);
    end
  endtask

  task automatic test_reset();
    axi_tresetn      = 1'b0;
    enable_tx_encode = 1'b0;
    rsp_axis_tdata   = 32'h0;
    rsp_axis_tvalid  = 1'b0;
    rsp_axis_tlast   = 1'b0;
    rsp_axis_tdest   = 4'd0;
    rsp_axis_tuser   = 32'h0;
    repeat (3) @(negedge axi_tclk);
    vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tvalid got %b want 0", tvalid); end
    vectors++; if (tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tlast got %b want 0", tlast); end
    vectors++; if (tdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_tdata got %h want 0", tdata); end
    vectors++; if (rsp_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_tready got %b want 0", rsp_axis_tready); end
    vectors++; if (err_count !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_err_count got %h want 0", err_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    @(posedge axi_tclk);
    #1;
    axi_tresetn = 1'b1;
    repeat (2) @(negedge axi_tclk);
    vectors++; if (busy !== 1'b0 || tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_idle got busy=%b tvalid=%b want 0 0", busy, tvalid); end
  endtask

  task automatic test_basic_frame();
    out_q.delete();
    exp_q.delete();
    exp_q.push_back(33'h0_4444_4343);
    exp_q.push_back(33'h0_0000_0007);
    exp_q.push_back(33'h0_0000_0011);
    exp_q.push_back(33'h0_0000_0022);
    exp_q.push_back(33'h1_0000_0033);
    send_frame(4'd2, 32'h0000_0007, 3, 32'h11);
    wait_idle();
    vectors++;
    if (rise_cyc - start_cyc != 3) begin
      miscompares++;
      $display("[TB] FAIL header_latency got %0d want 3 falling edges after drive", rise_cyc - start_cyc);
    end
    vectors++;
    if (out_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL basic_count got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL basic_word %0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
      end
    end
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("[TB] FAIL basic_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_backpressure();
    out_q.delete();
    stall_err   = 0;
    tready_mode = 1;
    send_frame(4'd2, 32'h0000_0007, 3, 32'h11);
    wait_idle();
    tready_mode = 0;
    vectors++;
    if (out_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL stall_count got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL stall_word %0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
      end
    end
    vectors++; if (stall_err != 0) begin miscompares++; $display("[TB] FAIL stall_hold got %0d unstable cycles want 0", stall_err); end
  endtask

  task automatic test_drop_bad_dest();
    out_q.delete();
    rsp_beats = 0;
    send_frame(4'd5, 32'h0000_0055, 4, 32'h5);
    wait_idle();
    vectors++; if (out_q.size() != 0) begin miscompares++; $display("[TB] FAIL drop_words got %0d want 0", out_q.size()); end
    vectors++; if (rsp_beats != 4) begin miscompares++; $display("[TB] FAIL drop_beats got %0d want 4", rsp_beats); end
    vectors++; if (err_count !== 16'd1) begin miscompares++; $display("[TB] FAIL drop_err_count got %0d want 1", err_count); end
  endtask

  task automatic test_truncate();
    out_q.delete();
    exp_q.delete();
    rsp_beats = 0;
    exp_q.push_back(33'h0_4141_4646);
    exp_q.push_back(33'h0_CAFE_0001);
    exp_q.push_back(33'h0_0000_0010);
    exp_q.push_back(33'h0_0000_0020);
    exp_q.push_back(33'h0_0000_0030);
    exp_q.push_back(33'h1_0000_0040);
    send_frame(4'd1, 32'hCAFE_0001, 6, 32'h10);
    wait_idle();
    vectors++;
    if (out_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL trunc_count got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL trunc_word %0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
      end
    end
    vectors++; if (rsp_beats != 6) begin miscompares++; $display("[TB] FAIL trunc_beats got %0d want 6", rsp_beats); end
    vectors++; if (err_count !== 16'd2) begin miscompares++; $display("[TB] FAIL trunc_err_count got %0d want 2", err_count); end
  endtask

  task automatic test_exact_max();
    out_q.delete();
    exp_q.delete();
    exp_q.push_back(33'h0_4444_4646);
    exp_q.push_back(33'h0_0000_0BEE);
    exp_q.push_back(33'h0_0000_0003);
    exp_q.push_back(33'h0_0000_0006);
    exp_q.push_back(33'h0_0000_0009);
    exp_q.push_back(33'h1_0000_000C);
    send_frame(4'd3, 32'h0000_0BEE, 4, 32'h3);
    wait_idle();
    vectors++;
    if (out_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL exact_count got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL exact_word %0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
      end
    end
    vectors++; if (err_count !== 16'd2) begin miscompares++; $display("[TB] FAIL exact_err_count got %0d want 2", err_count); end
  endtask

  task automatic test_back_to_back();
    int guard;
    out_q.delete();
    exp_q.delete();
    exp_q.push_back(33'h0_4141_4343);
    exp_q.push_back(33'h0_0000_0100);
    exp_q.push_back(33'h0_0000_00A0);
    exp_q.push_back(33'h1_0000_0140);
    send_frame(4'd0, 32'h0000_0100, 2, 32'hA0);
    @(posedge axi_tclk);
    #1;
    enable_tx_encode = 1'b1;
    rsp_axis_tdest   = 4'd2;
    rsp_axis_tuser   = 32'h0000_0200;
    rsp_axis_tdata   = 32'h0000_00B0;
    rsp_axis_tlast   = 1'b0;
    rsp_axis_tvalid  = 1'b1;
    guard = 0;
    do begin
      @(negedge axi_tclk);
      guard++;
    end while (rsp_axis_tready !== 1'b1 && guard < 100);
    vectors++; if (rsp_axis_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_payload_reached got %b want 1", rsp_axis_tready); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_word %0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
      end
    end
    vectors++;
    if (rise_cyc - hs_cyc - 1 != IFG + 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap got %0d want %0d cycles", rise_cyc - hs_cyc - 1, IFG + 2);
    end
    vectors++; if (tvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_pre_reset_tvalid got %b want 1", tvalid); end
    vectors++; if (err_count !== 16'd2) begin miscompares++; $display("[TB] FAIL b2b_pre_reset_err got %0d want 2", err_count); end
    #2;
    axi_tresetn = 1'b0;
    #1;
    vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_tvalid got %b want 0", tvalid); end
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("[TB] FAIL async_reset_err got %0d want 0", err_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_busy got %b want 0", busy); end
    vectors++; if (rsp_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_rsp_tready got %b want 0", rsp_axis_tready); end
    enable_tx_encode = 1'b0;
    rsp_axis_tvalid  = 1'b0;
    repeat (2) @(posedge axi_tclk);
    #1;
    axi_tresetn = 1'b1;
    repeat (3) @(negedge axi_tclk);
    vectors++; if (busy !== 1'b0 || tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_async_idle got busy=%b tvalid=%b want 0 0", busy, tvalid); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_drop_bad_dest();
    test_truncate();
    test_exact_max();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
